spi_master_host: RTL

Host-side SPI master that drives the SPI slave + RAM subsystem over `SS_n` / `MOSI` / `MISO`. It sits directly upstream of the SPI slave. It accepts one command word per valid/ready handshake from a host or sequencer and serializes it MSB-first as a `MEM_WIDTH+2`-bit frame. For read-data commands, it then captures the `MEM_WIDTH`-bit reply on `MISO` and returns it as a one-cycle response.

---
 rtl/spi_master_host.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/spi_master_host.sv
// ---------------------------------------------------------------------------
// spi_master_host
//
// Host-side SPI master for the SPI slave + RAM subsystem. It accepts one
// command word per valid/ready handshake and shifts it out MSB-first as a
// (MEM_WIDTH+2)-bit frame {cmd, data}. The frame is preceded by a one-cycle
// select phase that already presents cmd[1]. For read-data commands (cmd 11)
// it waits TURNAROUND cycles, captures MEM_WIDTH bits from MISO, and returns
// them with a one-cycle rsp_valid pulse.
//
// Ports:
//   clk        system clock, also the SPI bit clock (one bit per cycle)
//   rst_n      synchronous active-low reset
//   req_valid  command valid from host
//   req_ready  high only while idle (combinational state decode)
//   req_cmd    00 write-addr, 01 write-data, 10 read-addr, 11 read-data
//   req_data   address/data payload, shifted for every command
//   rsp_valid  one-cycle pulse, rsp_data holds the read-data result
//   rsp_data   last captured MISO word, held until the next capture
//   busy       high whenever the master is not idle
//   SS_n       registered slave select, active low
//   MOSI       registered serial data to slave
//   MISO       serial data from slave
// ---------------------------------------------------------------------------
module spi_master_host #(
  parameter int MEM_WIDTH  = 8,
  parameter int TURNAROUND = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_cmd,
  input  logic [MEM_WIDTH-1:0] req_data,
  output logic                 rsp_valid,
  output logic [MEM_WIDTH-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int FRAME_W = MEM_WIDTH + 2;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    SHIFT,
    TURN,
    CAPTURE,
    GAP
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_next;
  logic [FRAME_W-1:0]   r_shift;
  logic [FRAME_W-1:0]   w_shift_next;
  logic                 r_is_read;
  logic                 w_is_read_next;
  logic                 r_ss_n;
  logic                 r_mosi;
  logic                 r_rsp_valid;
  logic [MEM_WIDTH-1:0] r_rsp_data;
  logic                 w_ss_n_next;
  logic                 w_mosi_next;
  logic                 w_rsp_valid_next;
  logic                 w_capture;

  // Next-state logic. The bit counter is loaded with (phase length - 1)
  // whenever a counted phase is entered and counts down to zero, so it never
  // wraps. The shift register is only advanced between SHIFT cycles; the SEL
  // cycle and the first SHIFT cycle both present frame[MSB] (cmd[1]).
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_shift_next   = r_shift;
    w_is_read_next = r_is_read;

    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_state_next   = SEL;
          w_shift_next   = {req_cmd, req_data};
          w_is_read_next = (req_cmd == 2'b11);
        end
      end
      SEL: begin
        w_state_next = SHIFT;
        w_cnt_next   = 4'(FRAME_W - 1);
      end
      SHIFT: begin
        if (r_cnt == 4'd0) begin
          if (r_is_read) begin
            w_state_next = TURN;
            w_cnt_next   = 4'(TURNAROUND - 1);
          end else begin
            w_state_next = GAP;
          end
        end else begin
          w_cnt_next   = r_cnt - 4'd1;
          w_shift_next = {r_shift[FRAME_W-2:0], 1'b0};
        end
      end
      TURN: begin
        if (r_cnt == 4'd0) begin
          w_state_next = CAPTURE;
          w_cnt_next   = 4'(MEM_WIDTH - 1);
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      CAPTURE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = GAP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      GAP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // The pins are registered from the next state so that SS_n/MOSI line up
  // with the state they belong to, i.e. SS_n falls in the SEL cycle itself.
  always_comb begin
    w_ss_n_next      = 1'b1;
    w_mosi_next      = 1'b0;
    w_rsp_valid_next = 1'b0;

    case (w_state_next)
      SEL, SHIFT: begin
        w_ss_n_next = 1'b0;
        w_mosi_next = w_shift_next[FRAME_W-1];
      end
      TURN, CAPTURE: begin
        w_ss_n_next = 1'b0;
      end
      GAP: begin
        w_rsp_valid_next = w_is_read_next;
      end
      default: begin
        w_ss_n_next = 1'b1;
      end
    endcase
  end

  assign w_capture = (r_state == CAPTURE);

  // State, counters and registered outputs. MISO is sampled at the edge that
  // closes each CAPTURE cycle and enters from the LSB side, so the first bit
  // received ends up as the MSB of rsp_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= '0;
      r_is_read   <= 1'b0;
      r_ss_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_shift     <= w_shift_next;
      r_is_read   <= w_is_read_next;
      r_ss_n      <= w_ss_n_next;
      r_mosi      <= w_mosi_next;
      r_rsp_valid <= w_rsp_valid_next;
      if (w_capture) begin
        r_rsp_data <= {r_rsp_data[MEM_WIDTH-2:0], MISO};
      end
    end
  end

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign SS_n      = r_ss_n;
  assign MOSI      = r_mosi;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
